// File: rtl/mmio_ctrl_pkg.sv
// Shared I/O-space definitions: base select, register offsets and decode helper
// used by the MMIO controller, the stage-3 load mux and software headers.
package mmio_ctrl_pkg;

  localparam logic [1:0] MMIO_IO_BASE_HI = 2'b10;

  localparam logic [7:0] MMIO_UART_CTRL = 8'h00;
  localparam logic [7:0] MMIO_UART_RX   = 8'h04;
  localparam logic [7:0] MMIO_UART_TX   = 8'h08;
  localparam logic [7:0] MMIO_CYC       = 8'h10;
  localparam logic [7:0] MMIO_INST      = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_RX,
    REG_TX,
    REG_CYC,
    REG_INST,
    REG_CNT_RST,
    REG_NONE
  } mmio_reg_e;

  // Decodes a word index (offset[7:2]); byte lanes within a word alias.
  function automatic mmio_reg_e decode_reg(input logic [5:0] word);
    mmio_reg_e r;
    case (word)
      MMIO_UART_CTRL[7:2]: r = REG_CTRL;
      MMIO_UART_RX[7:2]:   r = REG_RX;
      MMIO_UART_TX[7:2]:   r = REG_TX;
      MMIO_CYC[7:2]:       r = REG_CYC;
      MMIO_INST[7:2]:      r = REG_INST;
      MMIO_CNT_RST[7:2]:   r = REG_CNT_RST;
      default:             r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmio_ctrl_io_counter.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module io_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: UART RX pop / TX holding register, cycle and retired
// instruction counters, and a registered one-cycle-latency read port.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter logic [1:0]  IO_BASE_HI = MMIO_IO_BASE_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic        we,
  input  logic        instr_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [31:0] rdata
);

  logic      sel;
  logic      rd_en;
  logic      wr_en;
  mmio_reg_e reg_sel;

  assign sel     = (addr[31:30] == IO_BASE_HI);
  assign reg_sel = decode_reg(addr[7:2]);
  // A store takes precedence over a simultaneous load, so the load side
  // (including the RX pop) is suppressed whenever we is high.
  assign rd_en   = sel & re & ~we;
  assign wr_en   = sel & we;

  logic unused_addr_data;
  assign unused_addr_data = ^{addr[29:8], addr[1:0], wdata[31:8]};

  logic             cnt_clr;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] inst_cnt;

  assign cnt_clr = wr_en & (reg_sel == REG_CNT_RST);

  io_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (1'b1),
    .q   (cyc_cnt)
  );

  io_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (instr_retire),
    .q   (inst_cnt)
  );

  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] rd_val;
  logic        tx_fire;
  logic        tx_load;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL: rd_val = {30'b0, uart_rx_valid, ~tx_valid_q & uart_tx_ready};
      REG_RX:   rd_val = {24'b0, uart_rx_data};
      REG_CYC:  rd_val = 32'(cyc_cnt);
      REG_INST: rd_val = 32'(inst_cnt);
      default:  rd_val = '0;
    endcase
  end

  assign tx_fire = tx_valid_q & uart_tx_ready;
  assign tx_load = wr_en & (reg_sel == REG_TX) & (~tx_valid_q | tx_fire);

  always_comb begin
    rdata_d    = rdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (rd_en) begin
      rdata_d = rd_val;
    end
    if (tx_load) begin
      tx_data_d  = wdata[7:0];
      tx_valid_d = 1'b1;
    end else if (tx_fire) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign uart_rx_ready = ~rst & rd_en & (reg_sel == REG_RX) & uart_rx_valid;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: a register-map level model checked every cycle
// plus hand-computed expectations; a 4-bit-counter instance covers wrap-around.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic        instr_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_tx_ready;

  logic        rx_ready,  rx_ready4;
  logic [7:0]  tx_data,   tx_data4;
  logic        tx_valid,  tx_valid4;
  logic [31:0] rdata,     rdata4;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  mmio_ctrl #(.CNT_W(32), .IO_BASE_HI(2'b10)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .re            (re),
    .we            (we),
    .instr_retire  (instr_retire),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (rx_ready),
    .uart_tx_data  (tx_data),
    .uart_tx_valid (tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .rdata         (rdata)
  );

  mmio_ctrl #(.CNT_W(4), .IO_BASE_HI(2'b10)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .re            (re),
    .we            (we),
    .instr_retire  (instr_retire),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (rx_ready4),
    .uart_tx_data  (tx_data4),
    .uart_tx_valid (tx_valid4),
    .uart_tx_ready (uart_tx_ready),
    .rdata         (rdata4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Register-map model: state per the documented map, updated once per edge.
  logic [31:0] m_cyc, m_inst, m_rdata, m_rdata4;
  logic [3:0]  m_cyc4, m_inst4;
  logic [7:0]  m_txd;
  logic        m_txv;
  logic        m_rxr;

  function automatic logic [31:0] map_read(input logic [7:0] off, input logic [31:0] cyc,
                                           input logic [31:0] inst);
    case (off)
      8'h00:   return {30'b0, uart_rx_valid, ~m_txv & uart_tx_ready};
      8'h04:   return {24'b0, uart_rx_data};
      8'h10:   return cyc;
      8'h14:   return inst;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] off;
    logic       io, ld, st, fire;
    off  = addr[7:0] & 8'hFC;
    io   = (addr[31:30] == 2'b10);
    ld   = io && re && !we;
    st   = io && we;
    m_rxr = !rst && ld && off == 8'h04 && uart_rx_valid;
    if (rst) begin
      m_cyc = 0; m_inst = 0; m_cyc4 = 0; m_inst4 = 0;
      m_rdata = 0; m_rdata4 = 0; m_txv = 0; m_txd = 0;
    end else begin
      if (ld) begin
        m_rdata  = map_read(off, m_cyc, m_inst);
        m_rdata4 = map_read(off, {28'b0, m_cyc4}, {28'b0, m_inst4});
      end
      fire = m_txv && uart_tx_ready;
      if (st && off == 8'h08 && (!m_txv || fire)) begin
        m_txd = wdata[7:0];
        m_txv = 1'b1;
      end else if (fire) begin
        m_txv = 1'b0;
      end
      if (st && off == 8'h18) begin
        m_cyc = 0; m_inst = 0; m_cyc4 = 0; m_inst4 = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_cyc4 = m_cyc4 + 4'd1;
        if (instr_retire) begin
          m_inst  = m_inst + 1;
          m_inst4 = m_inst4 + 4'd1;
        end
      end
    end
    #1;
    chk("model_rdata",     rdata,            m_rdata);
    chk("model_rdata_w4",  rdata4,           m_rdata4);
    chk("model_tx_valid",  {31'b0, tx_valid}, {31'b0, m_txv});
    chk("model_tx_data",   {24'b0, tx_data},  {24'b0, m_txd});
    chk("model_rx_ready",  {31'b0, rx_ready}, {31'b0, m_rxr});
    chk("model_w4_tx",     {23'b0, tx_valid4, tx_data4}, {23'b0, m_txv, m_txd});
    chk("model_w4_rx",     {31'b0, rx_ready4}, {31'b0, m_rxr});
  end

  task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    addr = a; wdata = d; re = r; we = w;
  endtask

  // Drive one cycle's bus request and return after the edge consuming it.
  task automatic io(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    set_bus(a, d, r, w);
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] pat;
    rst = 1'b1;
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    instr_retire = 1'b0;
    uart_rx_data = 8'h00;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset, idle, read the cycle counter
    repeat (10) @(negedge clk);
    chk("rdata_before_read", rdata, 32'h0);
    io(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    chk("cycle_after_10", rdata, 32'd10);

    // RX pop with a byte present, then with the FIFO empty
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h5A;
    set_bus(32'h8000_0004, 32'h0, 1'b1, 1'b0);
    #1 chk("rx_ready_pop", {31'b0, rx_ready}, 32'h1);
    @(negedge clk);
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk("rx_ready_one_cycle", {31'b0, rx_ready}, 32'h0);
    chk("rx_byte", rdata, 32'h5A);
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h33;
    set_bus(32'h8000_0004, 32'h0, 1'b1, 1'b0);
    #1 chk("rx_ready_empty", {31'b0, rx_ready}, 32'h0);
    @(negedge clk);
    chk("rx_stale_byte", rdata, 32'h33);

    // TX holding register
    uart_tx_ready = 1'b0;
    io(32'h8000_0008, 32'h141, 1'b0, 1'b1);
    chk("tx_loaded_valid", {31'b0, tx_valid}, 32'h1);
    chk("tx_loaded_data", {24'b0, tx_data}, 32'h41);
    for (int i = 0; i < 3; i++) begin
      io(32'h0, 32'h0, 1'b0, 1'b0);
      chk("tx_held", {31'b0, tx_valid}, 32'h1);
    end
    io(32'h8000_0008, 32'h99, 1'b0, 1'b1);
    chk("tx_store_dropped", {24'b0, tx_data}, 32'h41);
    uart_rx_valid = 1'b1;
    io(32'h8000_0000, 32'h0, 1'b1, 1'b0);
    chk("status_tx_pending", rdata, 32'h2);
    uart_tx_ready = 1'b1;
    io(32'h0, 32'h0, 1'b0, 1'b0);
    chk("tx_drop_after_fire", {31'b0, tx_valid}, 32'h0);
    io(32'h8000_0000, 32'h0, 1'b1, 1'b0);
    chk("status_tx_free", rdata, 32'h3);
    io(32'h8000_0008, 32'h42, 1'b0, 1'b1);
    chk("tx_reload", {23'b0, tx_valid, tx_data}, 32'h142);
    io(32'h8000_0008, 32'h43, 1'b0, 1'b1);
    chk("tx_fire_and_store", {23'b0, tx_valid, tx_data}, 32'h143);
    io(32'h0, 32'h0, 1'b0, 1'b0);
    chk("tx_drained", {31'b0, tx_valid}, 32'h0);
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;

    // Instruction counter, clear, clear-beats-increment
    io(32'h8000_0018, 32'hDEAD_BEEF, 1'b0, 1'b1);
    pat = 10'b11_0110_1101;
    for (int i = 0; i < 10; i++) begin
      instr_retire = pat[i];
      io(32'h0, 32'h0, 1'b0, 1'b0);
    end
    instr_retire = 1'b0;
    io(32'h8000_0014, 32'h0, 1'b1, 1'b0);
    chk("inst_count_7", rdata, 32'd7);
    io(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    chk("cycle_since_clear", rdata, 32'd11);
    instr_retire = 1'b1;
    io(32'h8000_0018, 32'h0, 1'b0, 1'b1);
    instr_retire = 1'b0;
    io(32'h8000_0014, 32'h0, 1'b1, 1'b0);
    chk("clear_beats_inc", rdata, 32'd0);
    io(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    chk("cycle_counts_again", rdata, 32'd1);

    // Counter wrap (4-bit instance), unmapped and non-I/O accesses
    io(32'h8000_0018, 32'h0, 1'b0, 1'b1);
    repeat (15) io(32'h0, 32'h0, 1'b0, 1'b0);
    io(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    chk("w4_cycle_max", rdata4, 32'hF);
    io(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    chk("w4_cycle_wrap", rdata4, 32'h0);
    chk("w32_cycle_16", rdata, 32'd16);
    io(32'h4000_0010, 32'h0, 1'b1, 1'b0);
    chk("non_io_read_holds", rdata, 32'd16);
    io(32'h8000_0014, 32'h55, 1'b1, 1'b1);
    chk("re_we_holds", rdata, 32'd16);
    io(32'h8000_000C, 32'h0, 1'b1, 1'b0);
    chk("unmapped_read", rdata, 32'h0);

    // Reset with TX pending and a load in flight
    io(32'h8000_0008, 32'h55, 1'b0, 1'b1);
    chk("tx_pending_pre_rst", {31'b0, tx_valid}, 32'h1);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h77;
    set_bus(32'h8000_0004, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    #1 chk("rx_ready_in_rst", {31'b0, rx_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    uart_rx_valid = 1'b0;
    set_bus(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    #1 chk("rst_tx_dropped", {31'b0, tx_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    chk("rst_cycle_zero", rdata, 32'h0);
    io(32'h8000_0014, 32'h0, 1'b1, 1'b0);
    chk("rst_inst_zero", rdata, 32'h0);
    io(32'h8000_0010, 32'h0, 1'b1, 1'b0);
    chk("rst_cycle_restart", rdata, 32'd2);

    repeat (3) io(32'h0, 32'h0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
